pix_line_fifo: RTL
==================

PIX_LINE_FIFO -- requirements
Module: pix_line_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 240: width of one pixel word in bits (1..1152).
REQ-002 The block SHALL have parameter DEPTH_WIDTH, default 5: address width; DEPTH = 2**DEPTH_WIDTH words (5..20).
REQ-003 The block SHALL have parameter OUTPUT_REG, default 1: 1 adds a RAM output register in standard mode.
REQ-004 The block SHALL have parameter FWFT, default 0: 1 selects first-word-fall-through read mode.
REQ-005 The block SHALL have parameter ALMOST_FULL_NUM, default 25: almost_full threshold in words.
REQ-006 The block SHALL have parameter ALMOST_EMPTY_NUM, default 6: almost_empty threshold in words.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have ports flush (input, 1: synchronous pointer clear), wr_en (input, 1) and wr_data (input, DATA_WIDTH).
REQ-010 The block SHALL have ports rd_en (input, 1), rd_data (output, DATA_WIDTH) and rd_valid (output, 1: rd_data qualifier).
REQ-011 The block SHALL have outputs wr_full, almost_full, rd_empty and almost_empty, each 1 bit.
REQ-012 The block SHALL have output water_level, DEPTH_WIDTH+1 bits: occupancy in words, 0..DEPTH.
REQ-013 The block SHALL have outputs overflow and underflow, each 1 bit: sticky error flags.

Function
REQ-014 The block SHALL accept a write when wr_en=1 and (wr_full=0, or a read is accepted in the same cycle).
REQ-015 The block SHALL accept a read when rd_en=1 and rd_empty=0; a read to an empty FIFO is never accepted, even with a simultaneous write.
REQ-016 The block SHALL ignore a rejected write and set overflow; it SHALL ignore a rejected read and set underflow. Both flags hold until rst.
REQ-017 The block SHALL wrap pointers modulo DEPTH and SHALL use an extra MSB to distinguish full from empty.
REQ-018 The block SHALL register water_level, wr_full, rd_empty, almost_full and almost_empty, updating them the cycle after the accepting edge. Simultaneous accepted read and write SHALL leave water_level unchanged.
REQ-019 The block SHALL drive wr_full = (water_level==DEPTH), almost_full = (water_level>=ALMOST_FULL_NUM) and almost_empty = (water_level<=ALMOST_EMPTY_NUM).
REQ-020 In standard mode (FWFT=0), rd_data/rd_valid SHALL follow an accepted read by 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1); rd_valid SHALL pulse 1 cycle per read, and rd_data SHALL hold between reads.
REQ-021 In standard mode, rd_empty SHALL deassert 1 cycle after the first write into an empty FIFO.
REQ-022 In FWFT mode (FWFT=1), a head register SHALL present the oldest word with rd_valid = !rd_empty, and rd_en SHALL pop it; OUTPUT_REG SHALL be ignored.
REQ-023 In FWFT mode, rd_empty SHALL deassert 2 cycles after a write into an empty FIFO; back-to-back pops SHALL sustain 1 word/cycle; water_level SHALL include the head word.
REQ-024 The block SHALL return data in write order, with no loss or duplication, across any number of pointer wraps.
REQ-025 The block SHALL treat flush=1 as taking priority over wr_en/rd_en: it clears pointers, water_level, the head register and rd_valid next cycle, and does not clear overflow/underflow.

Reset
REQ-026 With rst=1 at a clock edge, the block SHALL set next cycle: water_level=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-027 The block SHALL give rst priority over flush, wr_en and rd_en; mid-operation reset discards contents, RAM contents are not cleared, and no rd_valid appears after reset for pre-reset reads.

Structure
REQ-028 The block SHALL take from shared package pix_buf_pkg the depth calculation function, default width/depth/threshold constants, and the mode constants STD/FWFT.
REQ-029 The block SHALL instantiate storage as sub-module pix_fifo_ram (simple dual-port, sync write, sync read, optional output register); control, flags and the FWFT head register SHALL stay in pix_line_fifo.

Verification
REQ-030 The bench SHALL cover: defaults, write 32 words 0xFF..FF decrementing, then 1 extra -> wr_full=1 after word 32, 33rd ignored, overflow=1, water_level=32.
REQ-031 The bench SHALL cover: then read 33 -> 32 words returned in order, rd_valid 2 cycles after each rd_en, 33rd read sets underflow=1, rd_empty=1.
REQ-032 The bench SHALL cover: fill to 25 -> almost_full=1 at 25, 0 at 24; drain to 6 -> almost_empty=1 at 6, 0 at 7.
REQ-033 The bench SHALL cover: FWFT=1, single write 0xA5 into empty -> rd_empty=0 and rd_data=0xA5 two cycles later; rd_en -> rd_empty=1 next cycle.
REQ-034 The bench SHALL cover: simultaneous rd_en+wr_en at full (32) for 100 cycles -> water_level stays 32, no error flags, in-order data across wraps.
REQ-035 The bench SHALL cover: flush at 10 words, then rst with overflow set -> flush: water_level=0, overflow held; rst: all outputs at reset values.

Source files
------------

// File: rtl/pix_buf_pkg.sv
// Shared constants and helpers for the pixel line buffer blocks.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pix_buf_pkg;

    // Default geometry and watermark thresholds
    localparam int DEF_DATA_WIDTH       = 240;
    localparam int DEF_DEPTH_WIDTH      = 5;
    localparam int DEF_ALMOST_FULL_NUM  = 25;
    localparam int DEF_ALMOST_EMPTY_NUM = 6;

    // Read-port modes
    localparam int STD  = 0;
    localparam int FWFT = 1;

    // Number of words addressed by an address of the given width
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/pix_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read, optional output register.
// Latency: rd_en to rd_data 1 cycle, or 2 cycles with OUTPUT_REG=1.
// Backpressure: none; the caller only issues legal reads/writes.
module pix_fifo_ram
    import pix_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_DEPTH_WIDTH,
    parameter int OUTPUT_REG  = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  out_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] oreg_q;

    // Storage array is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between reads; write-first forwarding lets a
    // prefetching reader pick up a word in the same cycle it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            if ((WRITE_FIRST != 0) && wr_en && (wr_addr == rd_addr)) begin
                rdata_q <= wr_data;
            end else begin
                rdata_q <= mem[rd_addr];
            end
        end
    end

    // Optional output stage, loaded only when the read register carries a fresh word.
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q <= '0;
        end else if (out_en) begin
            oreg_q <= rdata_q;
        end
    end

    assign rd_data = (OUTPUT_REG != 0) ? oreg_q : rdata_q;

endmodule

// File: rtl/pix_line_fifo.sv
// Single-clock pixel line FIFO with standard or first-word-fall-through read port.
// Latency: write to rd_empty low 1 cycle (std) / 2 cycles (FWFT); rd_en to rd_valid 1+OUTPUT_REG cycles (std).
// Backpressure: writes refused while wr_full unless a read retires the same cycle; reads refused while rd_empty; refusals set sticky flags.
module pix_line_fifo
    import pix_buf_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int DEPTH_WIDTH      = DEF_DEPTH_WIDTH,
    parameter int OUTPUT_REG       = 1,
    parameter int FWFT             = STD,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              PW        = DEPTH_WIDTH + 1;
    localparam bit              IS_FWFT   = (FWFT == pix_buf_pkg::FWFT);
    localparam logic [PW-1:0]   DEPTH_LVL = PW'(depth_of(DEPTH_WIDTH));
    localparam logic [PW-1:0]   AF_LVL    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0]   AE_LVL    = PW'(ALMOST_EMPTY_NUM);

    // Pointers carry one extra MSB so full and empty differ.
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level_nxt;
    logic [PW-1:0]         ram_cnt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ram_re;
    logic                  fetch;
    logic                  s1_vld;
    logic                  s1_move;
    logic                  head_vld;
    logic                  head_vld_nxt;
    logic [DATA_WIDTH-1:0] head_dat;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  v1;
    logic                  v2;

    assign rd_acc    = rd_en && !rd_empty;
    assign wr_acc    = wr_en && (!wr_full || rd_acc);
    assign level_nxt = water_level + PW'(wr_acc) - PW'(rd_acc);

    // FWFT prefetch: RAM read register is a staging slot (s1) in front of the head.
    // rd_ptr tracks words pulled out of the RAM, so ram_cnt excludes s1 and head.
    assign ram_cnt      = wr_ptr - rd_ptr;
    assign s1_move      = s1_vld && (!head_vld || rd_acc);
    assign fetch        = IS_FWFT && ((ram_cnt != '0) || wr_acc) && (!s1_vld || s1_move);
    assign head_vld_nxt = s1_move || (head_vld && !rd_acc);
    assign ram_re       = !flush && (IS_FWFT ? fetch : rd_acc);

    pix_fifo_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (DEPTH_WIDTH),
        .OUTPUT_REG  (IS_FWFT ? 0 : OUTPUT_REG),
        .WRITE_FIRST (IS_FWFT ? 1 : 0)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !flush),
        .wr_addr (wr_ptr[DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr[DEPTH_WIDTH-1:0]),
        .out_en  (v1),
        .rd_data (ram_q)
    );

    // Pointers, occupancy, registered status flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            water_level  <= level_nxt;
            wr_full      <= (level_nxt == DEPTH_LVL);
            almost_full  <= (level_nxt >= AF_LVL);
            almost_empty <= (level_nxt <= AE_LVL);
            rd_empty     <= IS_FWFT ? !head_vld_nxt : (level_nxt == '0);
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    // FWFT staging slot and head register; both stay idle in standard mode.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_vld   <= 1'b0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            if (fetch) begin
                s1_vld <= 1'b1;
            end else if (s1_move) begin
                s1_vld <= 1'b0;
            end
            head_vld <= head_vld_nxt;
            if (s1_move) begin
                head_dat <= ram_q;
            end
        end
    end

    // Standard-mode read-valid pipeline, one stage per RAM register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= rd_acc && !IS_FWFT;
            v2 <= v1;
        end
    end

    assign rd_data  = IS_FWFT ? head_dat : ram_q;
    assign rd_valid = IS_FWFT ? !rd_empty : ((OUTPUT_REG != 0) ? v2 : v1);

endmodule
